// File: rtl/past_hist_arbiter.sv
// past_hist_arbiter
// Shared history buffer for one sampled signal. It keeps a DEPTH-deep record
// of past values. NREQ requesters look up "value d samples ago" through a
// round-robin arbiter, and one answer returns per grant, one cycle later.
//
// Handshake (valid/ready):
//   A requester raises req_valid[i] and holds req_valid[i] and its req_depth
//   slice stable until it sees req_ready[i]=1. A transfer happens on the rising
//   edge where req_valid[i] & req_ready[i] are both 1. req_ready is one-hot
//   (or all zero) and is a purely combinational function of req_valid, ptr
//   and rst. Responses have no backpressure: rsp_valid is a single-cycle
//   pulse on the edge after the transfer, and the consumer must take it.
module past_hist_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 1,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               smp_en,
  input  logic [DW-1:0]      smp_data,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*LW-1:0] req_depth,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_known,
  output logic               rsp_stable,
  output logic               rsp_err
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]  hist [DEPTH];  // hist[0] is the newest sample
  logic [LW-1:0]  fill_cnt;      // valid samples held, saturates at DEPTH
  logic [IDW-1:0] ptr;           // round-robin search start

  // Arbitration results
  logic [NREQ-1:0] grant_vec;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic            grant_fire;

  // Lookup results for the granted requester
  logic [LW-1:0]   sel_depth;
  logic            lk_err;
  logic            lk_known;
  logic [DW-1:0]   lk_data;
  logic            lk_mismatch;
  logic            lk_stable;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------

  // Pick the first requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!grant_any && req_valid[(int'(ptr) + off) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = IDW'((int'(ptr) + off) % NREQ);
        grant_vec[(int'(ptr) + off) % NREQ] = 1'b1;
      end
    end
  end

  // A grant during reset is suppressed, so no response follows it.
  assign grant_fire = grant_any && !rst;
  assign req_ready  = rst ? '0 : grant_vec;

  // Move ptr to the slot after the winner. Without a grant, ptr holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (grant_idx == IDW'(NREQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + IDW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // History record
  // ---------------------------------------------------------------------------

  // Shift in a new sample on each strobe. Reset clears the record to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist[k] <= '0;
      end
    end else if (smp_en) begin
      hist[0] <= smp_data;
      for (int k = 1; k < DEPTH; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  // Count the samples taken so far, stopping at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (smp_en && (fill_cnt != LW'(DEPTH))) begin
      fill_cnt <= fill_cnt + LW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup (reads the pre-shift history of the current edge)
  // ---------------------------------------------------------------------------

  assign sel_depth = req_depth[int'(grant_idx) * LW +: LW];

  // Classify the lookback. An out-of-range d is an error and is never known.
  always_comb begin
    lk_err   = (sel_depth == '0) || (sel_depth > LW'(DEPTH));
    lk_known = !lk_err && (fill_cnt >= sel_depth);
  end

  // Select hist[d-1]. Unknown or erroneous lookups read as zero.
  always_comb begin
    lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (lk_known && (int'(sel_depth) == k + 1)) begin
        lk_data = hist[k];
      end
    end
  end

  // The result is stable when hist[0..d-1] all match hist[0]. For d==1 no
  // other entry is compared, so stable reduces to known.
  always_comb begin
    lk_mismatch = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if ((k < int'(sel_depth)) && (hist[k] != hist[0])) begin
        lk_mismatch = 1'b1;
      end
    end
    lk_stable = lk_known && !lk_mismatch;
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------

  // Present one registered response per grant. Idle cycles return to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_known  <= 1'b0;
      rsp_stable <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (grant_fire) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant_idx;
      rsp_data   <= lk_data;
      rsp_known  <= lk_known;
      rsp_stable <= lk_stable;
      rsp_err    <= lk_err;
    end else begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_known  <= 1'b0;
      rsp_stable <= 1'b0;
      rsp_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_past_hist_arbiter.sv
// Directed bench for past_hist_arbiter with NREQ=4, DEPTH=8, DW=1.
// Inputs are driven on the falling edge. Outputs are sampled #1 after the
// rising edge, or just after the falling edge for the combinational req_ready.
module tb_past_hist_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 1;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int IDW   = $clog2(NREQ);

  logic               clk;
  logic               rst;
  logic               smp_en;
  logic [DW-1:0]      smp_data;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*LW-1:0] req_depth;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_known;
  logic               rsp_stable;
  logic               rsp_err;

  // Packed response: {valid, id[1:0], data, known, stable, err}
  logic [6:0] rsp_vec;
  assign rsp_vec = {rsp_valid, rsp_id, rsp_data, rsp_known, rsp_stable, rsp_err};

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [NREQ-1:0] rdy;

  past_hist_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .smp_en(smp_en), .smp_data(smp_data),
    .req_valid(req_valid), .req_depth(req_depth), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_known(rsp_known), .rsp_stable(rsp_stable), .rsp_err(rsp_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; smp_en = 1'b0; req_valid = '0; req_depth = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sample(input logic v);
    @(negedge clk);
    smp_en = 1'b1; smp_data = v;
    @(posedge clk);
    #1 smp_en = 1'b0;
  endtask

  // Single-cycle request. Returns req_ready as seen before the edge. The
  // response is visible on return.
  task automatic lookup(input int id, input int d, output logic [NREQ-1:0] r);
    @(negedge clk);
    req_depth = '0;
    req_depth[id*LW +: LW] = LW'(d);
    req_valid = NREQ'(1) << id;
    #1 r = req_ready;
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    pulse_reset();
    chk_cnt++;
    if (rsp_vec !== 7'b0) $display("FAIL reset_rsp: got %b want %b", rsp_vec, 7'b0);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic_lookup();
    pulse_reset();
    sample(1'b1); sample(1'b0); sample(1'b1); sample(1'b0);
    lookup(0, 2, rdy);
    chk_cnt++;
    if (rdy !== 4'b0001) $display("FAIL basic_ready: got %b want 0001", rdy);
    else pass_cnt++;
    chk_cnt++;
    if (rsp_vec !== 7'b1_00_1_1_0_0) $display("FAIL basic_rsp: got %b want %b", rsp_vec, 7'b1_00_1_1_0_0);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL basic_pulse: got %b want 0", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_unknown();
    pulse_reset();
    sample(1'b1);
    lookup(1, 3, rdy);
    chk_cnt++;
    if (rdy !== 4'b0010) $display("FAIL unknown_ready: got %b want 0010", rdy);
    else pass_cnt++;
    chk_cnt++;
    if (rsp_vec !== 7'b1_01_0_0_0_0) $display("FAIL unknown_rsp: got %b want %b", rsp_vec, 7'b1_01_0_0_0_0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_rdy [5];
    logic [IDW-1:0]  exp_id  [5];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    pulse_reset();
    @(negedge clk);
    req_valid = 4'b1111;
    req_depth = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_cnt++;
      if (req_ready !== exp_rdy[c]) $display("FAIL rr_ready%0d: got %b want %b", c, req_ready, exp_rdy[c]);
      else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++;
      if (rsp_vec !== {1'b1, exp_id[c], 4'b0000})
        $display("FAIL rr_rsp%0d: got %b want %b", c, rsp_vec, {1'b1, exp_id[c], 4'b0000});
      else pass_cnt++;
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_err();
    pulse_reset();
    lookup(2, 0, rdy);
    chk_cnt++;
    if (rsp_vec !== 7'b1_10_0_0_0_1) $display("FAIL err_d0: got %b want %b", rsp_vec, 7'b1_10_0_0_0_1);
    else pass_cnt++;
    lookup(2, 9, rdy);
    chk_cnt++;
    if (rsp_vec !== 7'b1_10_0_0_0_1) $display("FAIL err_d9: got %b want %b", rsp_vec, 7'b1_10_0_0_0_1);
    else pass_cnt++;
    // ptr is now 3, so with req2 and req3 both pending, req3 wins.
    @(negedge clk);
    req_depth = {4'd1, 4'd1, 4'd0, 4'd0};
    req_valid = 4'b1100;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL err_ptr: got %b want 1000", req_ready);
    else pass_cnt++;
    @(posedge clk); #1 req_valid = '0;
    chk_cnt++;
    if (rsp_vec !== 7'b1_11_0_0_0_0) $display("FAIL err_ptr_rsp: got %b want %b", rsp_vec, 7'b1_11_0_0_0_0);
    else pass_cnt++;
  endtask

  task automatic test_pre_shift();
    pulse_reset();
    sample(1'b0);
    @(negedge clk);
    smp_en = 1'b1; smp_data = 1'b1;
    req_depth = {12'd0, 4'd1};
    req_valid = 4'b0001;
    @(posedge clk);
    #1 smp_en = 1'b0; req_valid = '0;
    chk_cnt++;
    if (rsp_vec !== 7'b1_00_0_1_1_0) $display("FAIL preshift_rsp: got %b want %b", rsp_vec, 7'b1_00_0_1_1_0);
    else pass_cnt++;
    lookup(0, 1, rdy);
    chk_cnt++;
    if (rsp_vec !== 7'b1_00_1_1_1_0) $display("FAIL postshift_d1: got %b want %b", rsp_vec, 7'b1_00_1_1_1_0);
    else pass_cnt++;
    lookup(0, 2, rdy);
    chk_cnt++;
    if (rsp_vec !== 7'b1_00_0_1_0_0) $display("FAIL postshift_d2: got %b want %b", rsp_vec, 7'b1_00_0_1_0_0);
    else pass_cnt++;
  endtask

  task automatic test_full_and_reset_drop();
    pulse_reset();
    for (int i = 0; i < 8; i++) sample(1'b1);
    lookup(1, 8, rdy);
    chk_cnt++;
    if (rsp_vec !== 7'b1_01_1_1_1_0) $display("FAIL full_d8: got %b want %b", rsp_vec, 7'b1_01_1_1_1_0);
    else pass_cnt++;
    // Grant attempt in the same cycle as reset.
    @(negedge clk);
    rst = 1'b1;
    req_depth = {8'd0, 4'd1, 4'd0};
    req_valid = 4'b0010;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    chk_cnt++;
    if (rsp_vec !== 7'b0) $display("FAIL rst_drop: got %b want %b", rsp_vec, 7'b0);
    else pass_cnt++;
    lookup(1, 1, rdy);
    chk_cnt++;
    if (rdy !== 4'b0010) $display("FAIL after_rst_ready: got %b want 0010", rdy);
    else pass_cnt++;
    chk_cnt++;
    if (rsp_vec !== 7'b1_01_0_0_0_0) $display("FAIL after_rst_d1: got %b want %b", rsp_vec, 7'b1_01_0_0_0_0);
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; smp_en = 1'b0; smp_data = '0; req_valid = '0; req_depth = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic_lookup();
    test_unknown();
    test_back_to_back();
    test_err();
    test_pre_shift();
    test_full_and_reset_drop();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
